// File: rtl/ccip_pipe_bridge_if.sv
// Platform/AFU signal bundle for ccip_pipe_bridge. The slave modport is the
// bridge's view; the master modport is the platform/AFU stimulus side.
interface ccip_pipe_bridge_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 512
);
   logic                     soft_reset_in;
   logic                     soft_reset_out;
   logic [NUM_CH-1:0]        rx_valid_in;
   logic [NUM_CH*DATA_W-1:0] rx_data_in;
   logic [NUM_CH-1:0]        rx_valid_out;
   logic [NUM_CH*DATA_W-1:0] rx_data_out;
   logic [NUM_CH-1:0]        tx_valid_in;
   logic [NUM_CH*DATA_W-1:0] tx_data_in;
   logic [NUM_CH-1:0]        tx_valid_out;
   logic [NUM_CH*DATA_W-1:0] tx_data_out;
   logic [NUM_CH-1:0]        tx_almfull_in;
   logic [NUM_CH-1:0]        tx_almfull_out;
   logic [NUM_CH-1:0]        overflow_err;

   modport slave (
      input  soft_reset_in, rx_valid_in, rx_data_in, tx_valid_in, tx_data_in, tx_almfull_in,
      output soft_reset_out, rx_valid_out, rx_data_out, tx_valid_out, tx_data_out,
             tx_almfull_out, overflow_err
   );

   modport master (
      output soft_reset_in, rx_valid_in, rx_data_in, tx_valid_in, tx_data_in, tx_almfull_in,
      input  soft_reset_out, rx_valid_out, rx_data_out, tx_valid_out, tx_data_out,
             tx_almfull_out, overflow_err
   );
endinterface

// File: rtl/ccip_pipe_bridge.sv
// Fixed-latency CCI-P register slice: DEPTH-stage Rx/Tx pipes, a pipelined and
// stretched soft reset, and per-channel almost-full slack violation tracking.
module ccip_pipe_bridge #(
   parameter int NUM_CH      = 2,
   parameter int DATA_W      = 512,
   parameter int DEPTH       = 2,
   parameter int RST_STRETCH = 4,
   parameter int ALM_SLACK   = 8
) (
   input logic               clk,
   input logic               reset,
   ccip_pipe_bridge_if.slave bus
);
   localparam int               CNT_W     = $clog2(ALM_SLACK + 1) + 1;
   localparam logic [CNT_W-1:0] SLACK_C   = CNT_W'(ALM_SLACK);
   localparam logic [3:0]       STRETCH_C = 4'(RST_STRETCH);

   logic [NUM_CH-1:0]        rxVldP [DEPTH];
   logic [NUM_CH-1:0]        txVldP [DEPTH];
   logic [NUM_CH*DATA_W-1:0] rxDatP [DEPTH];
   logic [NUM_CH*DATA_W-1:0] txDatP [DEPTH];
   logic [DEPTH-1:0]         srP;
   logic [3:0]               stretchCnt;
   logic                     softRstOut;
   logic [NUM_CH-1:0]        txVldOut;
   logic [NUM_CH-1:0]        almReg;
   logic [CNT_W-1:0]         almCnt [NUM_CH];
   logic [NUM_CH-1:0]        ovfErr;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Valid and soft-reset delay lines
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            rxVldP[i] <= '0;
            txVldP[i] <= '0;
         end
         srP <= '0;
      end else begin
         rxVldP[0] <= bus.rx_valid_in;
         txVldP[0] <= bus.tx_valid_in;
         srP[0]    <= bus.soft_reset_in;
         for (int i = 1; i < DEPTH; i++) begin
            rxVldP[i] <= rxVldP[i-1];
            txVldP[i] <= txVldP[i-1];
            srP[i]    <= srP[i-1];
         end
      end
   end

   // Payload delay lines: meaningful only alongside their valid, so never reset
   always_ff @(posedge clk) begin
      rxDatP[0] <= bus.rx_data_in;
      txDatP[0] <= bus.tx_data_in;
      for (int i = 1; i < DEPTH; i++) begin
         rxDatP[i] <= rxDatP[i-1];
         txDatP[i] <= txDatP[i-1];
      end
   end

   // Stretch: reload while the pipelined source is high, so a re-assertion restarts it
   always_ff @(posedge clk) begin
      if (reset) begin
         stretchCnt <= 4'd0;
      end else if (srP[DEPTH-1]) begin
         stretchCnt <= STRETCH_C;
      end else if (stretchCnt != 4'd0) begin
         stretchCnt <= stretchCnt - 4'd1;
      end
   end

   assign softRstOut = srP[DEPTH-1] | (stretchCnt != 4'd0);
   assign txVldOut   = txVldP[DEPTH-1] & {NUM_CH{~softRstOut}};

   // Slack monitor: counts requests issued under almost-full; report-only
   always_ff @(posedge clk) begin
      if (reset) begin
         almReg <= '0;
         ovfErr <= '0;
         for (int c = 0; c < NUM_CH; c++) almCnt[c] <= '0;
      end else begin
         almReg <= bus.tx_almfull_in;
         for (int c = 0; c < NUM_CH; c++) begin
            if (!bus.tx_almfull_in[c]) begin
               almCnt[c] <= '0;
            end else if (txVldOut[c]) begin
               almCnt[c] <= satInc(almCnt[c]);
            end
            if (txVldOut[c] && bus.tx_almfull_in[c] && (almCnt[c] == SLACK_C)) begin
               ovfErr[c] <= 1'b1;
            end
         end
      end
   end

   assign bus.soft_reset_out = softRstOut;
   assign bus.rx_valid_out   = rxVldP[DEPTH-1] & {NUM_CH{~softRstOut}};
   assign bus.rx_data_out    = rxDatP[DEPTH-1];
   assign bus.tx_valid_out   = txVldOut;
   assign bus.tx_data_out    = txDatP[DEPTH-1];
   assign bus.tx_almfull_out = almReg | bus.tx_almfull_in;
   assign bus.overflow_err   = ovfErr;
endmodule

// File: tb/tb_ccip_pipe_bridge.sv
// Scoreboard bench for ccip_pipe_bridge: every issued beat is queued with the
// cycle it must emerge in; per-scenario tasks check reset, soft reset and slack.
module tb_ccip_pipe_bridge;
   localparam int NCH   = 2;
   localparam int DW    = 32;
   localparam int DEPTH = 2;
   localparam int STR   = 4;
   localparam int SLACK = 8;

   typedef struct {
      int            due;
      logic [DW-1:0] dat;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   passed = 0;
   int   total  = 0;
   exp_t rxQ [NCH][$];
   exp_t txQ [NCH][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ccip_pipe_bridge_if #(.NUM_CH(NCH), .DATA_W(DW)) ifc ();

   ccip_pipe_bridge #(
      .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .RST_STRETCH(STR), .ALM_SLACK(SLACK)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (ifc)
   );

   // Consumer side: each emerging beat must match the oldest queued one, on its due cycle
   always @(negedge clk) begin : monitor
      exp_t e;
      for (int c = 0; c < NCH; c++) begin
         if (rxQ[c].size() > 0 && rxQ[c][0].due < cyc) begin
            e = rxQ[c].pop_front();
            total++;
            $display("FAIL rx_missing ch%0d: got no beat by cycle %0d, required data %h at cycle %0d", c, cyc, e.dat, e.due);
         end
         if (txQ[c].size() > 0 && txQ[c][0].due < cyc) begin
            e = txQ[c].pop_front();
            total++;
            $display("FAIL tx_missing ch%0d: got no beat by cycle %0d, required data %h at cycle %0d", c, cyc, e.dat, e.due);
         end
         if (ifc.rx_valid_out[c] === 1'b1) begin
            total++;
            if (rxQ[c].size() == 0) begin
               $display("FAIL rx_unexpected ch%0d: got beat %h at cycle %0d, required none", c, ifc.rx_data_out[c*DW +: DW], cyc);
            end else begin
               e = rxQ[c].pop_front();
               if (e.due !== cyc || ifc.rx_data_out[c*DW +: DW] !== e.dat)
                  $display("FAIL rx_beat ch%0d: got %h at cycle %0d, required %h at cycle %0d", c, ifc.rx_data_out[c*DW +: DW], cyc, e.dat, e.due);
               else
                  passed++;
            end
         end
         if (ifc.tx_valid_out[c] === 1'b1) begin
            total++;
            if (txQ[c].size() == 0) begin
               $display("FAIL tx_unexpected ch%0d: got beat %h at cycle %0d, required none", c, ifc.tx_data_out[c*DW +: DW], cyc);
            end else begin
               e = txQ[c].pop_front();
               if (e.due !== cyc || ifc.tx_data_out[c*DW +: DW] !== e.dat)
                  $display("FAIL tx_beat ch%0d: got %h at cycle %0d, required %h at cycle %0d", c, ifc.tx_data_out[c*DW +: DW], cyc, e.dat, e.due);
               else
                  passed++;
            end
         end
      end
   end

   // Drive one cycle of Rx/Tx traffic; queue the beats that are expected to emerge
   task automatic step(input logic [NCH-1:0] rv, input logic [NCH-1:0] tv, input bit push);
      @(posedge clk);
      #1;
      ifc.rx_valid_in = rv;
      ifc.tx_valid_in = tv;
      for (int c = 0; c < NCH; c++) begin
         ifc.rx_data_in[c*DW +: DW] = DW'($urandom);
         ifc.tx_data_in[c*DW +: DW] = DW'($urandom);
         if (push && rv[c]) rxQ[c].push_back(exp_t'{cyc + DEPTH, ifc.rx_data_in[c*DW +: DW]});
         if (push && tv[c]) txQ[c].push_back(exp_t'{cyc + DEPTH, ifc.tx_data_in[c*DW +: DW]});
      end
   endtask

   task automatic applyReset(input int n);
      @(posedge clk);
      #1;
      reset             = 1'b1;
      ifc.soft_reset_in = 1'b0;
      ifc.rx_valid_in   = '0;
      ifc.tx_valid_in   = '0;
      repeat (n - 1) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Soft-reset output at offset i: pipelined source high within the last STR+1 cycles
   function automatic bit expSr(input logic [15:0] pat, input int i);
      for (int j = i - DEPTH - STR; j <= i - DEPTH; j++)
         if (j >= 0 && j < 16 && pat[j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic test_reset();
      ifc.tx_almfull_in = 2'b10;
      applyReset(3);
      @(negedge clk);
      total++;
      if (ifc.rx_valid_out !== 2'b00) $display("FAIL reset_rx_valid: got %b, required 00", ifc.rx_valid_out);
      else passed++;
      total++;
      if (ifc.tx_valid_out !== 2'b00) $display("FAIL reset_tx_valid: got %b, required 00", ifc.tx_valid_out);
      else passed++;
      total++;
      if (ifc.soft_reset_out !== 1'b0) $display("FAIL reset_soft_reset_out: got %b, required 0", ifc.soft_reset_out);
      else passed++;
      total++;
      if (ifc.tx_almfull_out !== 2'b10) $display("FAIL reset_almfull_out: got %b, required 10", ifc.tx_almfull_out);
      else passed++;
      total++;
      if (ifc.overflow_err !== 2'b00) $display("FAIL reset_overflow_err: got %b, required 00", ifc.overflow_err);
      else passed++;
      ifc.tx_almfull_in = 2'b00;
   endtask

   task automatic test_rx_single();
      int t0;
      step(2'b01, 2'b00, 1'b0);
      ifc.rx_data_in[DW-1:0] = 32'h0000_00A5;
      rxQ[0].push_back(exp_t'{cyc + DEPTH, 32'h0000_00A5});
      t0 = cyc;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step(2'b00, 2'b00, 1'b0);
         @(negedge clk);
         total++;
         if (ifc.rx_valid_out[0] !== (cyc == t0 + DEPTH))
            $display("FAIL rx_single_valid offset %0d: got %b, required %b", i, ifc.rx_valid_out[0], (cyc == t0 + DEPTH));
         else
            passed++;
         if (cyc == t0 + DEPTH) begin
            total++;
            if (ifc.rx_data_out[DW-1:0] !== 32'h0000_00A5)
               $display("FAIL rx_single_data: got %h, required 000000a5", ifc.rx_data_out[DW-1:0]);
            else
               passed++;
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 40; i++) step(2'($urandom), 2'($urandom), 1'b1);
      repeat (DEPTH + 1) step(2'b00, 2'b00, 1'b0);
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         total++;
         if (rxQ[c].size() !== 0) $display("FAIL stream_rx_drain ch%0d: got %0d pending, required 0", c, rxQ[c].size());
         else passed++;
         total++;
         if (txQ[c].size() !== 0) $display("FAIL stream_tx_drain ch%0d: got %0d pending, required 0", c, txQ[c].size());
         else passed++;
      end
   endtask

   // Rx ch0 streams every cycle; Tx ch1 is held only where its output lands in the gated window
   task automatic test_soft_reset(input logic [15:0] pat);
      for (int i = 0; i < 20; i++) begin
         step(2'b01, {expSr(pat, i + DEPTH), 1'b0}, !expSr(pat, i + DEPTH));
         ifc.soft_reset_in = (i < 16) ? pat[i] : 1'b0;
         @(negedge clk);
         total++;
         if (ifc.soft_reset_out !== expSr(pat, i))
            $display("FAIL soft_reset_out pat %h offset %0d: got %b, required %b", pat, i, ifc.soft_reset_out, expSr(pat, i));
         else
            passed++;
         total++;
         if (ifc.tx_valid_out[1] !== 1'b0)
            $display("FAIL soft_reset_tx_gate pat %h offset %0d: got %b, required 0", pat, i, ifc.tx_valid_out[1]);
         else
            passed++;
      end
      repeat (DEPTH + 1) step(2'b00, 2'b00, 1'b0);
      @(negedge clk);
      total++;
      if (rxQ[0].size() !== 0) $display("FAIL soft_reset_rx_drain: got %0d pending, required 0", rxQ[0].size());
      else passed++;
   endtask

   // ch0 issues SLACK+1 requests under almost-full, ch1 exactly SLACK
   task automatic test_overflow();
      step(2'b00, 2'b00, 1'b0);
      ifc.tx_almfull_in = 2'b11;
      step(2'b00, 2'b00, 1'b0);
      for (int i = 0; i < 14; i++) begin
         step(2'b00, {1'(i < SLACK), 1'(i < SLACK + 1)}, 1'b1);
         @(negedge clk);
         total++;
         if (ifc.overflow_err !== {1'b0, 1'(i >= SLACK + 1 + DEPTH)})
            $display("FAIL overflow_err offset %0d: got %b, required %b", i, ifc.overflow_err, {1'b0, 1'(i >= SLACK + 1 + DEPTH)});
         else
            passed++;
      end
      step(2'b00, 2'b00, 1'b0);
      ifc.tx_almfull_in = 2'b00;
      @(negedge clk);
      total++;
      if (ifc.tx_almfull_out !== 2'b11) $display("FAIL almfull_out_hold: got %b, required 11", ifc.tx_almfull_out);
      else passed++;
      step(2'b00, 2'b00, 1'b0);
      @(negedge clk);
      total++;
      if (ifc.tx_almfull_out !== 2'b00) $display("FAIL almfull_out_release: got %b, required 00", ifc.tx_almfull_out);
      else passed++;
      total++;
      if (ifc.overflow_err !== 2'b01) $display("FAIL overflow_sticky: got %b, required 01", ifc.overflow_err);
      else passed++;
      applyReset(2);
      @(negedge clk);
      total++;
      if (ifc.overflow_err !== 2'b00) $display("FAIL overflow_cleared_by_reset: got %b, required 00", ifc.overflow_err);
      else passed++;
   endtask

   // 5 requests, one cycle of almfull low, then 8 more: the gap must clear the count
   task automatic test_almfull_gap();
      for (int i = 0; i < 25; i++) begin
         step(2'b00, {1'b0, 1'((i < 5) || (i >= 10 && i < 18))}, 1'b1);
         ifc.tx_almfull_in = {1'b0, 1'(i != 9)};
         @(negedge clk);
         if (i == 9) begin
            total++;
            if (ifc.tx_almfull_out[0] !== 1'b1) $display("FAIL almfull_out_registered: got %b, required 1", ifc.tx_almfull_out[0]);
            else passed++;
         end
      end
      total++;
      if (ifc.overflow_err !== 2'b00) $display("FAIL almfull_gap_overflow: got %b, required 00", ifc.overflow_err);
      else passed++;
      ifc.tx_almfull_in = 2'b00;
   endtask

   task automatic test_reset_inflight();
      step(2'b00, 2'b00, 1'b0);
      ifc.tx_almfull_in = 2'b11;
      step(2'b00, 2'b11, 1'b0);
      step(2'b00, 2'b11, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset           = 1'b0;
      ifc.tx_valid_in = 2'b00;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (ifc.tx_valid_out !== 2'b00) $display("FAIL inflight_tx_valid offset %0d: got %b, required 00", i, ifc.tx_valid_out);
         else passed++;
         total++;
         if (ifc.overflow_err !== 2'b00) $display("FAIL inflight_overflow offset %0d: got %b, required 00", i, ifc.overflow_err);
         else passed++;
         step(2'b00, 2'b00, 1'b0);
      end
      ifc.tx_almfull_in = 2'b00;
   endtask

   initial begin
      ifc.soft_reset_in = 1'b0;
      ifc.rx_valid_in   = '0;
      ifc.tx_valid_in   = '0;
      ifc.rx_data_in    = '0;
      ifc.tx_data_in    = '0;
      ifc.tx_almfull_in = '0;
      test_reset();
      test_rx_single();
      test_back_to_back();
      test_soft_reset(16'h0003);
      test_soft_reset(16'h0011);
      test_overflow();
      test_almfull_gap();
      test_reset_inflight();
      repeat (4) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end
endmodule
